pvp_hit_resolver: RTL and testbench
===================================

Name: pvp_hit_resolver

Overview:
- Resolves hits among NUM_PLAYERS fighters once per frame, on the SCEN frame tick.
- Tracks per-player health, hitstun timers and KO flags, and runs a match state machine (FIGHT/OVER).
- Sits between the per-player player_attack/player_move instances and player_state_anim, and drives the hitstun_active input that is currently tied low.

Parameters:
- NUM_PLAYERS, 2: number of fighters. Legal range 2..8.
- HP_MAX, 100: starting health. Must fit in 8 bits.
- DMG, 10: health removed per landed hit.
- HITSTUN_FRAMES, 12: hitstun duration in frames. Must fit in 6 bits.
- HIT_RANGE_X, 40: maximum |dx| in pixels for a hit to connect.
- HIT_RANGE_Y, 48: maximum |dy| in pixels for a hit to connect.
- RESTART_FRAMES, 120: OVER-to-FIGHT delay in frames. Used only when PVP_ROUND_RESTART_EN is defined.

Ports:
- clk  in  1  pixel clock (25 MHz).
- reset  in  1  synchronous, active-high.
- SCEN  in  1  frame-tick enable. All state advances only on cycles where SCEN=1.
- pos_x  in  10*NUM_PLAYERS  player k's x on bits [10k+9:10k], unsigned.
- pos_y  in  10*NUM_PLAYERS  player k's y on the same slicing.
- facing_right  in  NUM_PLAYERS  1 = player k faces +x.
- attack_damage  in  NUM_PLAYERS  player k's hitbox-active window.
- health  out  8*NUM_PLAYERS  current HP per player.
- hitstun_active  out  NUM_PLAYERS  1 while player k's hitstun counter is nonzero.
- hit_pulse  out  NUM_PLAYERS  one-frame flag: player k was struck this frame.
- ko  out  NUM_PLAYERS  player k health == 0.
- match_over  out  1  state == OVER.
- winner  out  3  index of the surviving player. Valid only when match_over=1 and draw=0.
- draw  out  1  match ended with no player alive.
- round_num  out  4  rounds completed. Stays 0 unless PVP_ROUND_RESTART_EN is defined.

Behaviour:
- Interface: single clock clk. Reset is synchronous and active-high.
- Reset values:
  - health = HP_MAX for every player.
  - hitstun counters = 0; hitstun_active = 0; hit_pulse = 0; ko = 0.
  - state = FIGHT; match_over = 0; winner = 0; draw = 0; round_num = 0.
  - All landed latches = 0.
- Reset mid-match restores all of the above on the next clk edge, regardless of SCEN.
- Timing: every output is registered. Inputs are sampled on the SCEN cycle, and results are visible on the following cycle. Latency is 1 clk after SCEN.
- Landed latch L[i], per attacker:
  - Set when attacker i lands at least one hit.
  - Cleared on any SCEN where attack_damage[i]=0.
  - Result: at most one hit per attack window per attacker.
- Hit condition, evaluated on SCEN while state == FIGHT. Attacker i strikes defender j (j != i) when all of the following hold:
  - attack_damage[i]=1, L[i]=0, ko[i]=0;
  - ko[j]=0 and hitstun[j]=0;
  - |x_i - x_j| <= HIT_RANGE_X and |y_i - y_j| <= HIT_RANGE_Y, computed with 11-bit signed differences;
  - facing: facing_right[i] ? x_j >= x_i : x_j <= x_i. Equal x connects in either direction.
- Defender update on being struck:
  - health[j] -= DMG × (number of attackers striking j this frame), saturating at 0.
  - hitstun[j] loads HITSTUN_FRAMES once, even if struck by several attackers.
  - hit_pulse[j] = 1 for this frame only.
- Simultaneous mutual hits (i strikes j and j strikes i in the same frame) both apply, i.e. a trade. Hitstun is judged on pre-update values.
- Hitstun counters decrement by 1 on each SCEN while nonzero and not reloaded that frame.
- A KO'd player's hitstun is forced to 0.
- ko[j] is set whenever health[j] == 0.
- Match FSM:
  - FIGHT → OVER on the SCEN where the number of non-KO players becomes <= 1.
  - On that transition: winner = lowest-index surviving player, draw = 0. If no player survives, draw = 1 and winner = 0.
  - In OVER: no hits are resolved, health is frozen, hitstun counters drain to 0.
  - Without the optional feature, OVER is held until reset.
- SCEN=0: all state holds, and hit_pulse retains its last registered value until the next SCEN.

Optional Feature:
- Macro: PVP_ROUND_RESTART_EN.
- Defined:
  - OVER counts RESTART_FRAMES SCEN ticks, then returns to FIGHT.
  - On return: health reloads to HP_MAX; ko, L, hitstun, draw and winner clear.
  - round_num increments and saturates at 15.
- Undefined: OVER is terminal until reset, and round_num is tied to 0.

Test Plan:
- Reset state: NUM_PLAYERS=2, assert reset for 2 clks → health = 100/100, ko = 0, hitstun_active = 0, match_over = 0.
- Single hit: P0 at x=100 facing right, P1 at x=130, same y. Hold attack_damage[0] for 7 SCENs → exactly one hit. health[1] = 90; hit_pulse[1] high for 1 frame; hitstun_active[1] high for 12 SCENs, then low.
- Out of range / wrong facing, each case with attack_damage[0] held → health[1] stays 100:
  - P1 at x=141;
  - P0 facing left with P1 at x=130.
- Trade: both attack on the same SCEN while facing each other at dx=20 → both players' health = 90, both hitstun_active = 1.
- KO: land 10 separate attacks on P1 (releasing attack_damage between them, waiting out hitstun) → health[1] = 0, ko[1] = 1, match_over = 1, winner = 0, draw = 0. A further attack leaves health[0] unchanged.
- Multi-defender and restart: NUM_PLAYERS=3 with PVP_ROUND_RESTART_EN defined. P0 strikes P1 and P2 on the same frame → both drop to 90 and L[0] is set. Drive a KO to OVER; after 120 SCENs → state = FIGHT, health = 100 for all, round_num = 1.

Source files
------------

// File: rtl/pvp_hit_resolver.sv
// Per-frame hit resolution among NUM_PLAYERS fighters: health, hitstun, KO flags and a FIGHT/OVER match FSM.
// Define PVP_ROUND_RESTART_EN to return from OVER to FIGHT after RESTART_FRAMES ticks and count rounds.
module pvp_hit_resolver #(
    parameter int NUM_PLAYERS    = 2,
    parameter int HP_MAX         = 100,
    parameter int DMG            = 10,
    parameter int HITSTUN_FRAMES = 12,
    parameter int HIT_RANGE_X    = 40,
    parameter int HIT_RANGE_Y    = 48,
    parameter int RESTART_FRAMES = 120
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      SCEN,
    input  logic [10*NUM_PLAYERS-1:0] pos_x,
    input  logic [10*NUM_PLAYERS-1:0] pos_y,
    input  logic [NUM_PLAYERS-1:0]    facing_right,
    input  logic [NUM_PLAYERS-1:0]    attack_damage,
    output logic [8*NUM_PLAYERS-1:0]  health,
    output logic [NUM_PLAYERS-1:0]    hitstun_active,
    output logic [NUM_PLAYERS-1:0]    hit_pulse,
    output logic [NUM_PLAYERS-1:0]    ko,
    output logic                      match_over,
    output logic [2:0]                winner,
    output logic                      draw,
    output logic [3:0]                round_num
);

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8 || HP_MAX > 255 || HITSTUN_FRAMES > 63 ||
        RESTART_FRAMES < 1) begin : g_bad_param
        $error("pvp_hit_resolver: illegal parameter value");
    end

    typedef enum logic {FIGHT = 1'b0, OVER = 1'b1} state_t;

    state_t                                  state;
    logic [NUM_PLAYERS-1:0][5:0]             stun;
    logic [NUM_PLAYERS-1:0]                  landed;

    logic [NUM_PLAYERS-1:0][NUM_PLAYERS-1:0] strike;
    logic [NUM_PLAYERS-1:0][3:0]             hits;
    logic [NUM_PLAYERS-1:0][7:0]             health_nx;
    logic [NUM_PLAYERS-1:0][5:0]             stun_nx;
    logic [NUM_PLAYERS-1:0]                  ko_nx;
    logic [NUM_PLAYERS-1:0]                  pulse_nx;
    logic [NUM_PLAYERS-1:0]                  landed_nx;
    logic [NUM_PLAYERS-1:0]                  active_nx;
    logic [3:0]                              alive_nx;
    logic [2:0]                              first_alive_nx;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[10] ? 10'(-d) : d[9:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] hp, input logic [3:0] n);
        logic [11:0] loss;
        loss = 12'(DMG) * 12'(n);
        return (12'(hp) <= loss) ? 8'd0 : 8'(12'(hp) - loss);
    endfunction

    // strike[i][j]: attacker i connects on defender j this frame
    always_comb begin
        strike = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (state == FIGHT && i != j &&
                    attack_damage[i] && !landed[i] && !ko[i] &&
                    !ko[j] && stun[j] == 6'd0 &&
                    abs_diff(pos_x[10*i +: 10], pos_x[10*j +: 10]) <= 10'(HIT_RANGE_X) &&
                    abs_diff(pos_y[10*i +: 10], pos_y[10*j +: 10]) <= 10'(HIT_RANGE_Y) &&
                    (facing_right[i] ? (pos_x[10*j +: 10] >= pos_x[10*i +: 10])
                                     : (pos_x[10*j +: 10] <= pos_x[10*i +: 10])))
                    strike[i][j] = 1'b1;
            end
        end
    end

    always_comb begin
        hits           = '0;
        health_nx      = '0;
        stun_nx        = '0;
        ko_nx          = '0;
        pulse_nx       = '0;
        landed_nx      = '0;
        active_nx      = '0;
        alive_nx       = '0;
        first_alive_nx = '0;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            for (int i = 0; i < NUM_PLAYERS; i++)
                hits[j] = hits[j] + 4'(strike[i][j]);
            health_nx[j] = sat_sub(health[8*j +: 8], hits[j]);
            ko_nx[j]     = (health_nx[j] == 8'd0);
            pulse_nx[j]  = (hits[j] != 4'd0);
            // One reload per frame no matter how many attackers connected
            if (ko_nx[j])
                stun_nx[j] = 6'd0;
            else if (pulse_nx[j])
                stun_nx[j] = 6'(HITSTUN_FRAMES);
            else if (stun[j] != 6'd0)
                stun_nx[j] = stun[j] - 6'd1;
            else
                stun_nx[j] = 6'd0;
            active_nx[j] = (stun_nx[j] != 6'd0);
            landed_nx[j] = attack_damage[j] & (landed[j] | (|strike[j]));
        end
        // Descending scan leaves the lowest surviving index in first_alive_nx
        for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
            if (!ko_nx[k]) begin
                alive_nx       = alive_nx + 4'd1;
                first_alive_nx = 3'(k);
            end
        end
    end

`ifdef PVP_ROUND_RESTART_EN
    localparam int RCW = $clog2(RESTART_FRAMES) + 1;
    logic [RCW-1:0] restart_cnt;
`else
    assign round_num = 4'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            health         <= {NUM_PLAYERS{8'(HP_MAX)}};
            stun           <= '0;
            hitstun_active <= '0;
            hit_pulse      <= '0;
            ko             <= '0;
            landed         <= '0;
            state          <= FIGHT;
            match_over     <= 1'b0;
            winner         <= 3'd0;
            draw           <= 1'b0;
`ifdef PVP_ROUND_RESTART_EN
            restart_cnt    <= '0;
            round_num      <= 4'd0;
`endif
        end else if (SCEN) begin
            health         <= health_nx;
            stun           <= stun_nx;
            hitstun_active <= active_nx;
            hit_pulse      <= pulse_nx;
            ko             <= ko_nx;
            landed         <= landed_nx;
            case (state)
                FIGHT: begin
                    if (alive_nx <= 4'd1) begin
                        state      <= OVER;
                        match_over <= 1'b1;
                        winner     <= first_alive_nx;
                        draw       <= (alive_nx == 4'd0);
`ifdef PVP_ROUND_RESTART_EN
                        restart_cnt <= '0;
`endif
                    end
                end
                OVER: begin
`ifdef PVP_ROUND_RESTART_EN
                    if (restart_cnt == RCW'(RESTART_FRAMES - 1)) begin
                        state          <= FIGHT;
                        match_over     <= 1'b0;
                        health         <= {NUM_PLAYERS{8'(HP_MAX)}};
                        ko             <= '0;
                        landed         <= '0;
                        stun           <= '0;
                        hitstun_active <= '0;
                        hit_pulse      <= '0;
                        draw           <= 1'b0;
                        winner         <= 3'd0;
                        round_num      <= (round_num == 4'd15) ? round_num : round_num + 4'd1;
                    end else begin
                        restart_cnt <= restart_cnt + RCW'(1);
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pvp_hit_resolver.sv
// Scoreboard bench for pvp_hit_resolver: a 2-player and a 3-player instance, directed frames with hand-computed results.
module tb_pvp_hit_resolver;

    typedef struct {
        string       tag;
        logic [23:0] h;
        logic [2:0]  hs;
        logic [2:0]  hp;
        logic [2:0]  ko;
        logic        mo;
        logic [2:0]  win;
        logic        dr;
        logic [3:0]  rn;
    } exp_t;

    bit          clk = 1'b0;
    logic        reset;
    logic        scen2, scen3;
    logic [19:0] pos_x2, pos_y2;
    logic [1:0]  fr2, att2;
    logic [29:0] pos_x3, pos_y3;
    logic [2:0]  fr3, att3;

    logic [15:0] health2;
    logic [1:0]  hs2, hp2, ko2;
    logic        mo2, dr2;
    logic [2:0]  win2;
    logic [3:0]  rn2;
    logic [23:0] health3;
    logic [2:0]  hs3, hp3, ko3;
    logic        mo3, dr3;
    logic [2:0]  win3;
    logic [3:0]  rn3;

    exp_t q2[$];
    exp_t q3[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pvp_hit_resolver #(.NUM_PLAYERS(2)) u2 (
        .clk(clk), .reset(reset), .SCEN(scen2),
        .pos_x(pos_x2), .pos_y(pos_y2), .facing_right(fr2), .attack_damage(att2),
        .health(health2), .hitstun_active(hs2), .hit_pulse(hp2), .ko(ko2),
        .match_over(mo2), .winner(win2), .draw(dr2), .round_num(rn2)
    );

    pvp_hit_resolver #(.NUM_PLAYERS(3)) u3 (
        .clk(clk), .reset(reset), .SCEN(scen3),
        .pos_x(pos_x3), .pos_y(pos_y3), .facing_right(fr3), .attack_damage(att3),
        .health(health3), .hitstun_active(hs3), .hit_pulse(hp3), .ko(ko3),
        .match_over(mo3), .winner(win3), .draw(dr3), .round_num(rn3)
    );

    function automatic exp_t mk(input string t, input logic [23:0] h, input logic [2:0] hs,
                                input logic [2:0] hp, input logic [2:0] k, input logic mo,
                                input logic [2:0] w, input logic d, input logic [3:0] rn);
        exp_t e;
        e.tag = t; e.h = h; e.hs = hs; e.hp = hp; e.ko = k;
        e.mo = mo; e.win = w; e.dr = d; e.rn = rn;
        return e;
    endfunction

    function automatic logic [23:0] h2(input int a, input int b);
        return {8'd0, 8'(b), 8'(a)};
    endfunction

    function automatic logic [23:0] h3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic check(input exp_t e, input logic [23:0] h, input logic [2:0] hs,
                         input logic [2:0] hp, input logic [2:0] k, input logic mo,
                         input logic [2:0] w, input logic d, input logic [3:0] rn);
        n_cmp++;
        if (h !== e.h || hs !== e.hs || hp !== e.hp || k !== e.ko || mo !== e.mo ||
            w !== e.win || d !== e.dr || rn !== e.rn) begin
            n_bad++;
            $display("FAIL %s: got h=%h hs=%b hp=%b ko=%b over=%b win=%0d draw=%b round=%0d, want h=%h hs=%b hp=%b ko=%b over=%b win=%0d draw=%b round=%0d",
                     e.tag, h, hs, hp, k, mo, w, d, rn,
                     e.h, e.hs, e.hp, e.ko, e.mo, e.win, e.dr, e.rn);
        end
    endtask

    // Monitor: every reset or SCEN cycle of an instance owes one expectation from its queue
    always @(posedge clk) begin
        bit   do2, do3;
        exp_t e;
        do2 = reset || scen2;
        do3 = reset || scen3;
        #1;
        if (do2) begin
            if (q2.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL q2_empty: got an output frame, want a queued expectation");
            end else begin
                e = q2.pop_front();
                check(e, {8'd0, health2}, {1'b0, hs2}, {1'b0, hp2}, {1'b0, ko2}, mo2, win2, dr2, rn2);
            end
        end
        if (do3) begin
            if (q3.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL q3_empty: got an output frame, want a queued expectation");
            end else begin
                e = q3.pop_front();
                check(e, health3, hs3, hp3, ko3, mo3, win3, dr3, rn3);
            end
        end
    end

    task automatic frame2(input logic [1:0] att, input exp_t e);
        @(negedge clk);
        att2 = att; scen2 = 1'b1;
        q2.push_back(e);
        @(negedge clk);
        scen2 = 1'b0;
    endtask

    task automatic frame3(input logic [2:0] att, input exp_t e);
        @(negedge clk);
        att3 = att; scen3 = 1'b1;
        q3.push_back(e);
        @(negedge clk);
        scen3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, want completion within 200us");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; scen2 = 1'b0; scen3 = 1'b0; att2 = '0; att3 = '0;
        pos_x2 = {10'd130, 10'd100}; pos_y2 = {10'd200, 10'd200}; fr2 = 2'b01;
        pos_x3 = {10'd140, 10'd120, 10'd100}; pos_y3 = {3{10'd200}}; fr3 = 3'b001;
        for (int k = 0; k < 2; k++) begin
            q2.push_back(mk("reset2", h2(100, 100), 3'b000, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));
            q3.push_back(mk("reset3", h3(100, 100, 100), 3'b000, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single hit: attack held 7 frames lands once, hitstun lasts 12 frames
        for (int k = 1; k <= 13; k++)
            frame2((k <= 7) ? 2'b01 : 2'b00,
                   mk("single_hit", h2(100, 90), (k <= 12) ? 3'b010 : 3'b000,
                      (k == 1) ? 3'b010 : 3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));

        // Wrong facing, then just out of range
        fr2 = 2'b00;
        for (int k = 0; k < 3; k++)
            frame2(2'b01, mk("wrong_facing", h2(100, 90), 3'b000, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));
        fr2 = 2'b01; pos_x2 = {10'd141, 10'd100};
        for (int k = 0; k < 3; k++)
            frame2(2'b01, mk("out_of_range", h2(100, 90), 3'b000, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));

        // dx exactly HIT_RANGE_X connects
        pos_x2 = {10'd140, 10'd100};
        frame2(2'b01, mk("edge_range", h2(100, 80), 3'b010, 3'b010, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));
        for (int k = 1; k <= 12; k++)
            frame2(2'b00, mk("edge_drain", h2(100, 80), (k < 12) ? 3'b010 : 3'b000,
                             3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));

        // Trade at dx=20
        pos_x2 = {10'd120, 10'd100};
        frame2(2'b11, mk("trade", h2(90, 70), 3'b011, 3'b011, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));
        for (int k = 1; k <= 12; k++)
            frame2(2'b00, mk("trade_drain", h2(90, 70), (k < 12) ? 3'b011 : 3'b000,
                             3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));

        // KO: seven more hits take P1 from 70 to 0
        pos_x2 = {10'd130, 10'd100};
        for (int m = 1; m <= 7; m++) begin
            frame2(2'b01, mk("ko_hit", h2(90, 70 - 10*m), (m < 7) ? 3'b010 : 3'b000, 3'b010,
                             (m == 7) ? 3'b010 : 3'b000, m == 7, 3'd0, 1'b0, 4'd0));
            if (m < 7)
                for (int k = 1; k <= 12; k++)
                    frame2(2'b00, mk("ko_drain", h2(90, 70 - 10*m), (k < 12) ? 3'b010 : 3'b000,
                                     3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));
        end
        for (int k = 0; k < 3; k++)
            frame2(2'b11, mk("over_frozen2", h2(90, 0), 3'b000, 3'b000, 3'b010, 1'b1, 3'd0, 1'b0, 4'd0));

        // Three players: P0 hits P1 and P2 at once; held attack does not re-land
        frame3(3'b001, mk("multi_def", h3(100, 90, 90), 3'b110, 3'b110, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));
        frame3(3'b001, mk("latch_hold", h3(100, 90, 90), 3'b110, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));
        for (int k = 1; k <= 11; k++)
            frame3(3'b000, mk("md_drain", h3(100, 90, 90), (k < 11) ? 3'b110 : 3'b000,
                              3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 4'd0));

        // P2 facing left strikes P0 and P1 until only P2 survives
        for (int m = 1; m <= 10; m++) begin
            frame3(3'b100, mk("p2_hit", h3(100 - 10*m, (m <= 9) ? 90 - 10*m : 0, 90),
                              (m < 9) ? 3'b011 : ((m == 9) ? 3'b001 : 3'b000),
                              (m < 10) ? 3'b011 : 3'b001,
                              (m < 9) ? 3'b000 : ((m == 9) ? 3'b010 : 3'b011),
                              m == 10, (m == 10) ? 3'd2 : 3'd0, 1'b0, 4'd0));
            if (m < 10)
                for (int k = 1; k <= 12; k++)
                    frame3(3'b000, mk("p2_drain", h3(100 - 10*m, 90 - 10*m, 90),
                                      (k < 12) ? ((m < 9) ? 3'b011 : 3'b001) : 3'b000, 3'b000,
                                      (m < 9) ? 3'b000 : 3'b010, 1'b0, 3'd0, 1'b0, 4'd0));
        end

`ifdef PVP_ROUND_RESTART_EN
        for (int k = 1; k <= 120; k++) begin
            if (k < 120)
                frame3(3'b000, mk("over_wait", h3(0, 0, 90), 3'b000, 3'b000, 3'b011, 1'b1, 3'd2, 1'b0, 4'd0));
            else
                frame3(3'b000, mk("restart", h3(100, 100, 100), 3'b000, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0, 4'd1));
        end
`else
        for (int k = 0; k < 3; k++)
            frame3(3'b001, mk("over_hold3", h3(0, 0, 90), 3'b000, 3'b000, 3'b011, 1'b1, 3'd2, 1'b0, 4'd0));
`endif

        repeat (4) @(negedge clk);
        n_cmp++;
        if (q2.size() + q3.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d unconsumed expectations, want 0", q2.size() + q3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
